// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory stage: opcodes, FSM states, opcode classifiers.
package mips_mem_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2b;
    localparam logic [5:0] OP_LL  = 6'h30;
    localparam logic [5:0] OP_SC  = 6'h38;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } lsu_state_e;

    // Plain stores only; SC is handled separately because of its link check.
    function automatic logic op_is_store(input logic [5:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Opcodes that return a value to the register file (loads and LL).
    function automatic logic op_is_load(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU) || (op == OP_LL);
    endfunction

    function automatic logic op_is_known(input logic [5:0] op);
        return op_is_load(op) || op_is_store(op) || (op == OP_SC);
    endfunction

    function automatic logic op_misaligned(input logic [5:0] op, input logic [1:0] a);
        logic half_op;
        logic word_op;
        half_op = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
        word_op = (op == OP_LW) || (op == OP_SW) || (op == OP_LL) || (op == OP_SC);
        return (half_op && a[0]) || (word_op && (a != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: write enables and replicated store data, plus load extraction/extension.
module lsu_lane_align
    import mips_mem_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic [5:0]        opcode,
    input  logic [1:0]        addr_lo,
    input  logic [WORD_W-1:0] wdata,
    input  logic [WORD_W-1:0] rdata,
    output logic [3:0]        be_c,
    output logic [WORD_W-1:0] wdata_c,
    output logic [WORD_W-1:0] load_data_c
);

    logic [1:0]  lane;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        lane        = BIG_ENDIAN ? ~addr_lo : addr_lo;
        byte_v      = rdata[{lane, 3'b000} +: 8];
        half_v      = rdata[{lane[1], 4'b0000} +: 16];
        be_c        = 4'b1111;
        wdata_c     = wdata;
        load_data_c = rdata;
        case (opcode)
            OP_SB: begin
                be_c    = 4'b0001 << lane;
                wdata_c = {4{wdata[7:0]}};
            end
            OP_SH: begin
                be_c    = 4'b0011 << {lane[1], 1'b0};
                wdata_c = {2{wdata[15:0]}};
            end
            OP_LB:  load_data_c = {{24{byte_v[7]}}, byte_v};
            OP_LBU: load_data_c = {24'd0, byte_v};
            OP_LH:  load_data_c = {{16{half_v[15]}}, half_v};
            OP_LHU: load_data_c = {16'd0, half_v};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MIPS memory stage: one access in flight against a req/ack port, with LL/SC link tracking.
module load_store_unit
    import mips_mem_pkg::*;
#(
    parameter bit          BIG_ENDIAN  = 1'b0,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [5:0]        ex_opcode,
    input  logic [WORD_W-1:0] ex_addr,
    input  logic [WORD_W-1:0] ex_wdata,
    input  logic [4:0]        ex_rt,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rt,
    output logic [WORD_W-1:0] wb_data,
    output logic              addr_err,
    output logic              bus_err,
    output logic [WORD_W-1:0] err_addr
);

    localparam int unsigned CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

    lsu_state_e        state_q, state_d;
    logic [5:0]        op_q, op_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [4:0]        rt_q, rt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              link_valid_q, link_valid_d;
    logic [29:0]       link_word_q, link_word_d;

    logic              ex_ready_q, ex_ready_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_rt_q, wb_rt_d;
    logic [WORD_W-1:0] wb_data_q, wb_data_d;
    logic              addr_err_q, addr_err_d;
    logic              bus_err_q, bus_err_d;
    logic [WORD_W-1:0] err_addr_q, err_addr_d;

    logic              accept;
    logic              sc_link_ok;
    logic [5:0]        al_op;
    logic [1:0]        al_addr;
    logic [3:0]        al_be;
    logic [WORD_W-1:0] al_wdata;
    logic [WORD_W-1:0] al_load;

    // Lane logic sees the incoming op while idle and the latched op while waiting for data.
    assign al_op   = (state_q == ST_IDLE) ? ex_opcode    : op_q;
    assign al_addr = (state_q == ST_IDLE) ? ex_addr[1:0] : addr_q[1:0];

    lsu_lane_align #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_align (
        .opcode      (al_op),
        .addr_lo     (al_addr),
        .wdata       (ex_wdata),
        .rdata       (mem_rdata),
        .be_c        (al_be),
        .wdata_c     (al_wdata),
        .load_data_c (al_load)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        rt_d         = rt_q;
        cnt_d        = cnt_q;
        link_valid_d = link_valid_q;
        link_word_d  = link_word_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        wb_valid_d   = 1'b0;
        wb_rt_d      = wb_rt_q;
        wb_data_d    = wb_data_q;
        addr_err_d   = 1'b0;
        bus_err_d    = 1'b0;
        err_addr_d   = err_addr_q;

        accept     = ex_valid && ex_ready_q;
        sc_link_ok = link_valid_q && (link_word_q == ex_addr[31:2]);

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d   = ex_opcode;
                    addr_d = ex_addr;
                    rt_d   = ex_rt;
                    cnt_d  = '0;
                    if ((ex_opcode == OP_SC) ||
                        (op_is_store(ex_opcode) && (ex_addr[31:2] == link_word_q))) begin
                        link_valid_d = 1'b0;
                    end
                    if (!op_is_known(ex_opcode)) begin
                        state_d = ST_IDLE;
                    end else if (op_misaligned(ex_opcode, ex_addr[1:0])) begin
                        state_d    = ST_ERR;
                        addr_err_d = 1'b1;
                        err_addr_d = ex_addr;
                    end else if ((ex_opcode == OP_SC) && !sc_link_ok) begin
                        state_d    = ST_DONE;
                        wb_valid_d = 1'b1;
                        wb_rt_d    = ex_rt;
                        wb_data_d  = '0;
                    end else begin
                        state_d     = ST_REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = op_is_store(ex_opcode) || (ex_opcode == OP_SC);
                        mem_addr_d  = {ex_addr[31:2], 2'b00};
                        mem_be_d    = al_be;
                        mem_wdata_d = al_wdata;
                    end
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    state_d   = ST_DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (op_is_load(op_q) || (op_q == OP_SC)) begin
                        wb_valid_d = 1'b1;
                        wb_rt_d    = rt_q;
                        wb_data_d  = (op_q == OP_SC) ? WORD_W'(1) : al_load;
                    end
                end else if (ACK_TIMEOUT != 0) begin
                    if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                        state_d    = ST_IDLE;
                        mem_req_d  = 1'b0;
                        mem_we_d   = 1'b0;
                        bus_err_d  = 1'b1;
                        err_addr_d = addr_q;
                    end else begin
                        cnt_d = CNT_W'(cnt_q + 1'b1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (op_q == OP_LL) begin
                    link_valid_d = 1'b1;
                    link_word_d  = addr_q[31:2];
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ex_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= '0;
            addr_q       <= '0;
            rt_q         <= '0;
            cnt_q        <= '0;
            link_valid_q <= 1'b0;
            link_word_q  <= '0;
            ex_ready_q   <= 1'b1;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            wb_valid_q   <= 1'b0;
            wb_rt_q      <= '0;
            wb_data_q    <= '0;
            addr_err_q   <= 1'b0;
            bus_err_q    <= 1'b0;
            err_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            rt_q         <= rt_d;
            cnt_q        <= cnt_d;
            link_valid_q <= link_valid_d;
            link_word_q  <= link_word_d;
            ex_ready_q   <= ex_ready_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            wb_valid_q   <= wb_valid_d;
            wb_rt_q      <= wb_rt_d;
            wb_data_q    <= wb_data_d;
            addr_err_q   <= addr_err_d;
            bus_err_q    <= bus_err_d;
            err_addr_q   <= err_addr_d;
        end
    end

    assign ex_ready  = ex_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_rt     = wb_rt_q;
    assign wb_data   = wb_data_q;
    assign addr_err  = addr_err_q;
    assign bus_err   = bus_err_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: little-endian lanes, LL/SC link, misalign, ack timeout, reset.
module tb_load_store_unit;
    import mips_mem_pkg::*;

    typedef struct packed {
        logic [4:0]  rt;
        logic [31:0] data;
    } wb_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [5:0]  ex_opcode;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic [4:0]  ex_rt;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rt;
    logic [31:0] wb_data;
    logic        addr_err;
    logic        bus_err;
    logic [31:0] err_addr;

    logic        ack_en;
    logic        pre_we;
    logic [7:0]  pre_idx;
    logic [31:0] pre_val;
    logic [31:0] mem [0:255];

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          n_wb   = 0;
    int          n_req  = 0;
    wb_exp_t     sb_q[$];

    always #5 clk = ~clk;

    load_store_unit #(
        .BIG_ENDIAN  (1'b0),
        .ACK_TIMEOUT (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ex_valid  (ex_valid),
        .ex_ready  (ex_ready),
        .ex_opcode (ex_opcode),
        .ex_addr   (ex_addr),
        .ex_wdata  (ex_wdata),
        .ex_rt     (ex_rt),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .wb_valid  (wb_valid),
        .wb_rt     (wb_rt),
        .wb_data   (wb_data),
        .addr_err  (addr_err),
        .bus_err   (bus_err),
        .err_addr  (err_addr)
    );

    // Zero-wait memory: ack in the same cycle as req when enabled.
    assign mem_ack   = mem_req && ack_en;
    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else begin
            if (pre_we) mem[pre_idx] <= pre_val;
            if (mem_req && mem_ack && mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Writeback scoreboard: every wb_valid pops the oldest expected entry.
    always @(negedge clk) begin
        if (mem_req) n_req++;
        if (wb_valid) begin
            wb_exp_t e;
            n_wb++;
            chk("wb_pending", 32'(sb_q.size() > 0), 32'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("wb_rt", 32'(wb_rt), 32'(e.rt));
                chk("wb_data", wb_data, e.data);
            end
        end
    end

    task automatic preload(input logic [7:0] idx, input logic [31:0] val);
        @(negedge clk);
        pre_we  = 1'b1;
        pre_idx = idx;
        pre_val = val;
        @(negedge clk);
        pre_we  = 1'b0;
    endtask

    // Presents one op; returns just after the accepting edge (start of cycle 1).
    task automatic issue(input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rt);
        int w = 0;
        @(negedge clk);
        while (!ex_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_issue", 32'(ex_ready), 32'd1);
        ex_valid  = 1'b1;
        ex_opcode = op;
        ex_addr   = a;
        ex_wdata  = wd;
        ex_rt     = rt;
        @(posedge clk);
        #1;
        ex_valid  = 1'b0;
        ex_opcode = '0;
        ex_addr   = '0;
        ex_wdata  = '0;
        ex_rt     = '0;
    endtask

    task automatic wait_idle(input string tag);
        int w = 0;
        @(negedge clk);
        while (!ex_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk(tag, 32'(ex_ready), 32'd1);
        #1;
    endtask

    task automatic push(input logic [4:0] rt, input logic [31:0] d);
        wb_exp_t e;
        e.rt   = rt;
        e.data = d;
        sb_q.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  t_op   [5];
        logic [31:0] t_addr [5];
        logic [31:0] t_exp  [5];
        int          base;

        rst_n = 1'b0; ex_valid = 1'b0; ex_opcode = '0; ex_addr = '0; ex_wdata = '0; ex_rt = '0;
        ack_en = 1'b1; pre_we = 1'b0; pre_idx = '0; pre_val = '0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_ex_ready", 32'(ex_ready), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        rst_n = 1'b1;

        // LB 0x103 with zero-wait ack: mem_req in cycle 1, wb_valid in cycle 2
        preload(8'h40, 32'h80FF_1234);
        push(5'd5, 32'hFFFF_FF80);
        issue(OP_LB, 32'h103, 32'h0, 5'd5);
        @(negedge clk);
        chk("lb_req", 32'(mem_req), 32'd1);
        chk("lb_addr", mem_addr, 32'h100);
        chk("lb_be", 32'(mem_be), 32'hF);
        chk("lb_we", 32'(mem_we), 32'd0);
        chk("lb_wb_early", 32'(wb_valid), 32'd0);
        @(negedge clk);
        chk("lb_wb_cycle2", 32'(wb_valid), 32'd1);
        chk("lb_req_drop", 32'(mem_req), 32'd0);
        wait_idle("lb_idle");

        // Remaining load extensions from the same word
        t_op[0] = OP_LBU; t_addr[0] = 32'h101; t_exp[0] = 32'h0000_0012;
        t_op[1] = OP_LH;  t_addr[1] = 32'h102; t_exp[1] = 32'hFFFF_80FF;
        t_op[2] = OP_LHU; t_addr[2] = 32'h100; t_exp[2] = 32'h0000_1234;
        t_op[3] = OP_LW;  t_addr[3] = 32'h100; t_exp[3] = 32'h80FF_1234;
        t_op[4] = OP_LB;  t_addr[4] = 32'h100; t_exp[4] = 32'h0000_0034;
        for (int i = 0; i < 5; i++) begin
            push(5'(i + 1), t_exp[i]);
            issue(t_op[i], t_addr[i], 32'h0, 5'(i + 1));
            wait_idle("ld_idle");
        end

        // SH 0x202: upper lanes, replicated halfword, no writeback
        base = n_wb;
        issue(OP_SH, 32'h202, 32'h0000_BEEF, 5'd3);
        @(negedge clk);
        chk("sh_we", 32'(mem_we), 32'd1);
        chk("sh_be", 32'(mem_be), 32'hC);
        chk("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
        chk("sh_addr", mem_addr, 32'h200);
        wait_idle("sh_idle");
        issue(OP_SB, 32'h201, 32'h0000_00AB, 5'd3);
        @(negedge clk);
        chk("sb_be", 32'(mem_be), 32'h2);
        chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        wait_idle("sb_idle");
        chk("store_no_wb", 32'(n_wb - base), 32'd0);
        push(5'd11, 32'hBEEF_AB00);
        issue(OP_LW, 32'h200, 32'h0, 5'd11);
        wait_idle("lw_st_idle");
        push(5'd12, 32'hFFFF_FFBE);
        issue(OP_LB, 32'h203, 32'h0, 5'd12);
        wait_idle("lb_st_idle");
        push(5'd13, 32'h0000_BEEF);
        issue(OP_LHU, 32'h202, 32'h0, 5'd13);
        wait_idle("lhu_st_idle");

        // Misaligned LW: addr_err, no memory access, ready two cycles after accept
        base = n_req;
        issue(OP_LW, 32'h6, 32'h0, 5'd4);
        @(negedge clk);
        chk("mis_addr_err", 32'(addr_err), 32'd1);
        chk("mis_err_addr", err_addr, 32'h6);
        chk("mis_ready_low", 32'(ex_ready), 32'd0);
        @(negedge clk);
        chk("mis_ready_back", 32'(ex_ready), 32'd1);
        chk("mis_err_drop", 32'(addr_err), 32'd0);
        #1;
        chk("mis_no_req", 32'(n_req - base), 32'd0);

        // Unknown opcode is consumed silently
        issue(6'h3F, 32'h100, 32'h0, 5'd6);
        @(negedge clk);
        chk("unk_ready", 32'(ex_ready), 32'd1);
        chk("unk_req", 32'(mem_req), 32'd0);

        // LL then SC succeeds; repeated SC fails without memory access
        preload(8'h10, 32'hCAFE_F00D);
        push(5'd7, 32'hCAFE_F00D);
        issue(OP_LL, 32'h40, 32'h0, 5'd7);
        wait_idle("ll_idle");
        push(5'd8, 32'd1);
        issue(OP_SC, 32'h40, 32'h1111_1111, 5'd8);
        @(negedge clk);
        chk("sc_req", 32'(mem_req), 32'd1);
        chk("sc_we", 32'(mem_we), 32'd1);
        chk("sc_be", 32'(mem_be), 32'hF);
        chk("sc_wdata", mem_wdata, 32'h1111_1111);
        wait_idle("sc_idle");
        base = n_req;
        push(5'd9, 32'd0);
        issue(OP_SC, 32'h40, 32'h2222_2222, 5'd9);
        wait_idle("sc2_idle");
        chk("sc2_no_req", 32'(n_req - base), 32'd0);

        // Store to the linked word breaks the link; store elsewhere does not
        push(5'd7, 32'h1111_1111);
        issue(OP_LL, 32'h40, 32'h0, 5'd7);
        wait_idle("ll2_idle");
        issue(OP_SB, 32'h41, 32'h0000_0022, 5'd0);
        wait_idle("sb41_idle");
        push(5'd8, 32'd0);
        issue(OP_SC, 32'h40, 32'h4444_4444, 5'd8);
        wait_idle("sc3_idle");
        push(5'd7, 32'h1111_2211);
        issue(OP_LL, 32'h40, 32'h0, 5'd7);
        wait_idle("ll3_idle");
        issue(OP_SB, 32'h44, 32'h0000_0055, 5'd0);
        wait_idle("sb44_idle");
        push(5'd8, 32'd1);
        issue(OP_SC, 32'h40, 32'h3333_3333, 5'd8);
        wait_idle("sc4_idle");
        push(5'd10, 32'h3333_3333);
        issue(OP_LW, 32'h40, 32'h0, 5'd10);
        wait_idle("lw40_idle");

        // Ack withheld: four REQ cycles then bus_err
        ack_en = 1'b0;
        base = n_wb;
        issue(OP_LW, 32'h80, 32'h0, 5'd14);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("to_req_held", 32'(mem_req), 32'd1);
        end
        @(negedge clk);
        chk("to_bus_err", 32'(bus_err), 32'd1);
        chk("to_req_drop", 32'(mem_req), 32'd0);
        chk("to_err_addr", err_addr, 32'h80);
        chk("to_ready", 32'(ex_ready), 32'd1);
        @(negedge clk);
        chk("to_bus_err_pulse", 32'(bus_err), 32'd0);
        #1;
        chk("to_no_wb", 32'(n_wb - base), 32'd0);

        // Async reset mid-REQ drops mem_req at once and no writeback follows
        base = n_wb;
        issue(OP_LW, 32'h84, 32'h0, 5'd15);
        @(negedge clk);
        chk("rr_req", 32'(mem_req), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rr_req_drop", 32'(mem_req), 32'd0);
        chk("rr_ready", 32'(ex_ready), 32'd1);
        @(negedge clk);
        rst_n  = 1'b1;
        ack_en = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        chk("rr_no_wb", 32'(n_wb - base), 32'd0);
        chk("rr_idle_req", 32'(mem_req), 32'd0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
